// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | systolic_pkg : shared defaults and FSM state type for the systolic array
// | Revision     : 1.0
// +----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEF_SYSTOLIC_ARRAY_WIDTH = 16;
    localparam int DEF_DATA_WIDTH_IN        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FILL   = 2'd2,
        LOADED = 2'd3
    } wl_state_e;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | weight_loader : streams one weight tile, row by row, into the top PE of a
// |                 systolic column, then issues a one-cycle switch pulse.
// |                 Optional short-tile zero fill: define WL_ZERO_FILL_EN.
// | Revision      : 1.0
// +----------------------------------------------------------------------------
module weight_loader
    import systolic_pkg::*;
#(
    parameter int  SYSTOLIC_ARRAY_WIDTH = DEF_SYSTOLIC_ARRAY_WIDTH,
    parameter int  DATA_WIDTH_IN        = DEF_DATA_WIDTH_IN,
    localparam int INDEX_WIDTH          = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wl_start_in,
    input  logic                            wl_valid_in,
    input  logic signed [DATA_WIDTH_IN-1:0] wl_weight_in,
    input  logic                            wl_last_in,
    output logic                            wl_ready_out,
    input  logic                            wl_switch_req_in,
    output logic                            wl_loaded_out,
    output logic signed [DATA_WIDTH_IN-1:0] col_weight_out,
    output logic [INDEX_WIDTH-1:0]          col_index_out,
    output logic                            col_accept_w_out,
    output logic                            col_switch_out
);

    localparam logic [INDEX_WIDTH-1:0] LAST_ROW = INDEX_WIDTH'(SYSTOLIC_ARRAY_WIDTH - 1);

    wl_state_e                       state_q, state_d;
    logic [INDEX_WIDTH-1:0]          row_q, row_d;
    logic signed [DATA_WIDTH_IN-1:0] weight_q, weight_d;
    logic [INDEX_WIDTH-1:0]          index_q, index_d;
    logic                            accept_q, accept_d;
    logic                            switch_q, switch_d;

`ifndef WL_ZERO_FILL_EN
    // Without zero fill every tile is full width, so the end-of-tile marker has no role.
    logic w_unused_last;
    assign w_unused_last = wl_last_in;
`endif

    assign wl_ready_out     = (state_q == LOAD);
    assign wl_loaded_out    = (state_q == LOADED);
    assign col_weight_out   = weight_q;
    assign col_index_out    = index_q;
    assign col_accept_w_out = accept_q;
    assign col_switch_out   = switch_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        weight_d = weight_q;
        index_d  = index_q;
        accept_d = 1'b0;
        switch_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (wl_start_in) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end

            LOAD: begin
                if (wl_valid_in) begin
                    accept_d = 1'b1;
                    weight_d = wl_weight_in;
                    index_d  = row_q;
                    if (row_q == LAST_ROW) begin
                        state_d = LOADED;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
`ifdef WL_ZERO_FILL_EN
                        if (wl_last_in) begin
                            state_d = FILL;
                        end
`endif
                    end
                end
            end

`ifdef WL_ZERO_FILL_EN
            // Pad the remaining rows of a short tile with zero weights.
            FILL: begin
                accept_d = 1'b1;
                weight_d = '0;
                index_d  = row_q;
                if (row_q == LAST_ROW) begin
                    state_d = LOADED;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
`endif

            LOADED: begin
                if (wl_switch_req_in) begin
                    switch_d = 1'b1;
                    row_d    = '0;
                    state_d  = wl_start_in ? LOAD : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            weight_q <= '0;
            index_q  <= '0;
            accept_q <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            weight_q <= weight_d;
            index_q  <= index_d;
            accept_q <= accept_d;
            switch_q <= switch_d;
        end
    end

endmodule : weight_loader
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_weight_loader : self-checking bench for weight_loader against a
// |                    tile-level reference model (rows issued, tile status).
// | Revision         : 1.0
// +----------------------------------------------------------------------------
module tb_weight_loader;

    localparam int W  = 16;
    localparam int DW = 8;
    localparam int IW = $clog2(W);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wl_start_in;
    logic                 wl_valid_in;
    logic signed [DW-1:0] wl_weight_in;
    logic                 wl_last_in;
    logic                 wl_ready_out;
    logic                 wl_switch_req_in;
    logic                 wl_loaded_out;
    logic signed [DW-1:0] col_weight_out;
    logic [IW-1:0]        col_index_out;
    logic                 col_accept_w_out;
    logic                 col_switch_out;

    always #5 clk = ~clk;

    weight_loader #(
        .SYSTOLIC_ARRAY_WIDTH (W),
        .DATA_WIDTH_IN        (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wl_start_in      (wl_start_in),
        .wl_valid_in      (wl_valid_in),
        .wl_weight_in     (wl_weight_in),
        .wl_last_in       (wl_last_in),
        .wl_ready_out     (wl_ready_out),
        .wl_switch_req_in (wl_switch_req_in),
        .wl_loaded_out    (wl_loaded_out),
        .col_weight_out   (col_weight_out),
        .col_index_out    (col_index_out),
        .col_accept_w_out (col_accept_w_out),
        .col_switch_out   (col_switch_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tile status plus the last row/weight handed to the column.
    bit                   m_loading;
    bit                   m_loaded;
    int                   m_row;
    int                   last_idx;
    logic signed [DW-1:0] last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_loaded  = 1'b0;
        m_row     = 0;
        last_idx  = 0;
        last_w    = '0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_ready"},  {31'd0, wl_ready_out},  {31'd0, m_loading});
        chk({tag, "_loaded"}, {31'd0, wl_loaded_out}, {31'd0, m_loaded});
    endtask

    task automatic feed(input logic v, input logic signed [DW-1:0] w, input logic last);
        bit acc;
        wl_valid_in  = v;
        wl_weight_in = w;
        wl_last_in   = last;
        acc = v && m_loading;
        step();
        wl_valid_in = 1'b0;
        wl_last_in  = 1'b0;
        chk("accept_w", {31'd0, col_accept_w_out}, {31'd0, acc});
        chk("no_switch", {31'd0, col_switch_out}, 32'd0);
        if (acc) begin
            last_w   = w;
            last_idx = m_row;
            m_row++;
            if (m_row == W) begin
                m_loading = 1'b0;
                m_loaded  = 1'b1;
                m_row     = 0;
            end
`ifdef WL_ZERO_FILL_EN
            else if (last) begin
                m_loading = 1'b0;
            end
`endif
        end
        chk("index", col_index_out, last_idx);
        chk("weight", col_weight_out, last_w);
        chk_status("feed");
    endtask

    task automatic start_tile();
        wl_start_in = 1'b1;
        step();
        wl_start_in = 1'b0;
        m_loading   = 1'b1;
        m_row       = 0;
        chk("start_ready", {31'd0, wl_ready_out}, 32'd1);
        chk("start_accept", {31'd0, col_accept_w_out}, 32'd0);
    endtask

    task automatic do_switch(input bit with_start);
        wl_switch_req_in = 1'b1;
        wl_start_in      = with_start;
        step();
        wl_switch_req_in = 1'b0;
        wl_start_in      = 1'b0;
        m_loaded  = 1'b0;
        m_loading = with_start;
        m_row     = 0;
        chk("switch_pulse", {31'd0, col_switch_out}, 32'd1);
        chk("switch_no_accept", {31'd0, col_accept_w_out}, 32'd0);
        chk_status("switch");
        if (!with_start) begin
            step();
            chk("switch_one_cycle", {31'd0, col_switch_out}, 32'd0);
            chk_status("after_switch");
        end
    endtask

    initial begin
        int guard;
        rst_n            = 1'b0;
        wl_start_in      = 1'b0;
        wl_valid_in      = 1'b0;
        wl_weight_in     = '0;
        wl_last_in       = 1'b0;
        wl_switch_req_in = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("rst_accept", {31'd0, col_accept_w_out}, 32'd0);
        chk("rst_switch", {31'd0, col_switch_out}, 32'd0);
        chk("rst_index", col_index_out, 32'd0);
        chk("rst_weight", col_weight_out, 32'd0);
        chk_status("rst");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_status("idle");

        // Switch request in IDLE produces no pulse
        wl_switch_req_in = 1'b1;
        step();
        wl_switch_req_in = 1'b0;
        chk("idle_switch", {31'd0, col_switch_out}, 32'd0);
        step();
        chk("idle_switch2", {31'd0, col_switch_out}, 32'd0);
        chk_status("idle_sw");

        // Full tile, continuous weights 1..16
        start_tile();
        for (int i = 0; i < W; i++) feed(1'b1, DW'(i + 1), 1'b0);
        feed(1'b0, '0, 1'b0);

        // Start alone while loaded is ignored
        wl_start_in = 1'b1;
        step();
        wl_start_in = 1'b0;
        chk_status("loaded_start");
        chk("loaded_start_switch", {31'd0, col_switch_out}, 32'd0);

        do_switch(1'b0);

        // Bubbles: 1,0,1,0 then random valid, with stray start/switch/last in LOAD
        start_tile();
        for (int i = 0; i < 4; i++) feed(1'(i % 2 == 0), DW'($urandom), 1'b0);
        guard = 0;
        while (m_loading && guard < 200) begin
            wl_start_in      = 1'($urandom_range(0, 1));
            wl_switch_req_in = 1'($urandom_range(0, 1));
`ifdef WL_ZERO_FILL_EN
            feed(1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
`else
            feed(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
`endif
            wl_start_in      = 1'b0;
            wl_switch_req_in = 1'b0;
            guard++;
        end
        chk("bubble_tile_done", {31'd0, m_loaded}, 32'd1);

        // Back-to-back: start and switch together in LOADED
        do_switch(1'b1);
        for (int i = 0; i < W; i++) feed(1'b1, DW'($urandom), 1'b0);
        chk("b2b_loaded", {31'd0, wl_loaded_out}, 32'd1);
        do_switch(1'b0);

        // Asynchronous reset mid-LOAD at row 7
        start_tile();
        for (int i = 0; i < 7; i++) feed(1'b1, DW'($urandom | 1), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_accept", {31'd0, col_accept_w_out}, 32'd0);
        chk("arst_switch", {31'd0, col_switch_out}, 32'd0);
        chk("arst_index", col_index_out, 32'd0);
        chk("arst_weight", col_weight_out, 32'd0);
        chk_status("arst");
        step();
        rst_n = 1'b1;
        step();
        chk_status("arst_idle");
        chk("arst_no_switch", {31'd0, col_switch_out}, 32'd0);

`ifdef WL_ZERO_FILL_EN
        // Short tile: -3, 5, 7 with last on 7, rows 3..15 zero filled
        start_tile();
        feed(1'b1, -8'sd3, 1'b0);
        feed(1'b1, 8'sd5, 1'b0);
        feed(1'b1, 8'sd7, 1'b1);
        for (int r = 3; r < W; r++) begin
            step();
            chk("fill_accept", {31'd0, col_accept_w_out}, 32'd1);
            chk("fill_index", col_index_out, r);
            chk("fill_weight", col_weight_out, 32'd0);
            chk("fill_ready", {31'd0, wl_ready_out}, 32'd0);
            chk("fill_loaded", {31'd0, wl_loaded_out}, {31'd0, r == W - 1});
        end
        m_loaded = 1'b1;
        last_idx = W - 1;
        last_w   = '0;
        step();
        chk("fill_done_accept", {31'd0, col_accept_w_out}, 32'd0);
        chk_status("fill_done");
        do_switch(1'b0);

        // Last on the final row is ordinary completion
        start_tile();
        for (int i = 0; i < W; i++) feed(1'b1, DW'(i), 1'(i == W - 1));
        chk("last_full_loaded", {31'd0, wl_loaded_out}, 32'd1);
        do_switch(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_weight_loader
`default_nettype wire

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter SYSTOLIC_ARRAY_WIDTH, default 16: number of PE rows in the fed column.
REQ-002 SHALL have parameter DATA_WIDTH_IN, default 8: signed weight width.
REQ-003 SHALL have localparam INDEX_WIDTH = $clog2(SYSTOLIC_ARRAY_WIDTH).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wl_start_in  in  1  request to begin loading one weight tile.
REQ-007 wl_valid_in  in  1  wl_weight_in valid.
REQ-008 wl_weight_in  in  DATA_WIDTH_IN  signed weight for the current row.
REQ-009 wl_last_in  in  1  final weight of a short tile; used only with WL_ZERO_FILL_EN.
REQ-010 wl_ready_out  out  1  loader accepts a weight this cycle.
REQ-011 wl_switch_req_in  in  1  request to activate the loaded tile.
REQ-012 wl_loaded_out  out  1  tile fully issued, awaiting switch.
REQ-013 col_weight_out  out  DATA_WIDTH_IN  to top PE pe_weight_in.
REQ-014 col_index_out  out  INDEX_WIDTH  to top PE pe_index_in.
REQ-015 col_accept_w_out  out  1  to top PE pe_accept_w_in.
REQ-016 col_switch_out  out  1  to top PE pe_switch_in.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FILL, LOADED.
REQ-018 IDLE: wl_start_in=1 -> LOAD with row counter cleared to 0; all other inputs ignored.
REQ-019 wl_ready_out SHALL be 1 only in LOAD, combinationally from state.
REQ-020 LOAD: on wl_valid_in && wl_ready_out, next cycle col_accept_w_out=1, col_weight_out=wl_weight_in, col_index_out=row counter; otherwise col_accept_w_out=0 next cycle.
REQ-021 Row counter SHALL increment per accepted weight; acceptance at row SYSTOLIC_ARRAY_WIDTH-1 -> LOADED, counter wraps to 0.
REQ-022 col_weight_out/col_index_out SHALL hold last value when col_accept_w_out=0.
REQ-023 Weights SHALL be issued in row order 0..SYSTOLIC_ARRAY_WIDTH-1, max one per cycle; bubbles on wl_valid_in=0 are legal.
REQ-024 LOADED: wl_loaded_out=1 (registered, asserted the cycle after last issue, combinationally from state).
REQ-025 LOADED with wl_switch_req_in=1 -> next cycle col_switch_out=1 for exactly one cycle; state -> IDLE.
REQ-026 LOADED with wl_switch_req_in=1 and wl_start_in=1 same cycle -> switch pulse and state -> LOAD (back-to-back tile, counter 0).
REQ-027 wl_start_in alone in LOADED, and wl_start_in/wl_switch_req_in in LOAD or FILL, SHALL be ignored.
REQ-028 wl_switch_req_in in IDLE SHALL be ignored; no switch pulse.
REQ-029 Switch SHALL never be issued in the same cycle as col_accept_w_out=1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, counter 0, every output 0.
REQ-031 Reset mid-LOAD or mid-FILL SHALL abandon the tile; no switch issued; rows already written keep whatever the PEs latched.

Configuration
REQ-032 Macro WL_ZERO_FILL_EN defined: in LOAD, accepted weight with wl_last_in=1 at row r<SYSTOLIC_ARRAY_WIDTH-1 -> FILL; FILL issues weight 0 to rows r+1..SYSTOLIC_ARRAY_WIDTH-1, one per cycle, wl_ready_out=0, then LOADED.
REQ-033 wl_last_in=1 at row SYSTOLIC_ARRAY_WIDTH-1 SHALL behave as normal completion.
REQ-034 Macro undefined: wl_last_in ignored, FILL unreachable and may be omitted; tiles always full width.

Structure
REQ-035 DATA_WIDTH_IN, SYSTOLIC_ARRAY_WIDTH defaults and the FSM state enum SHALL live in shared package systolic_pkg.
REQ-036 Single module; no sub-module.

Verification (SYSTOLIC_ARRAY_WIDTH=16, DATA_WIDTH_IN=8)
REQ-037 Reset: rst_n=0 mid-LOAD at row 7 -> all outputs 0 immediately, state IDLE, wl_ready_out=0.
REQ-038 Full tile: start, weights 1..16 continuous -> accept_w high 16 cycles, index 0..15 with weight index+1; wl_loaded_out=1 next cycle.
REQ-039 Bubbles: valid toggled 1,0,1,0 -> accept_w pattern mirrors accepts one cycle late; indices contiguous.
REQ-040 Switch: LOADED + switch_req -> col_switch_out=1 exactly one cycle, wl_loaded_out=0, IDLE; switch_req in IDLE -> no pulse.
REQ-041 Back-to-back: LOADED, start+switch_req same cycle -> switch pulse, wl_ready_out=1 next cycle, index restarts at 0.
REQ-042 WL_ZERO_FILL_EN: weights -3,5,7 with last on 7 -> rows 0..2 get -3,5,7; rows 3..15 get 0, ready=0 during fill; then LOADED.
